// File: rtl/conv_sequencer_if.sv
// Bus bundle between the convolution sequencer and its surroundings.
//  master : the sequencer (drives memory addresses, results and status)
//  slave  : control + rj/coeff/data memories + P2S (drive pulses and read data)
// Signals:
//  cfg_done, sample_valid, cur_addr      control handshake into the sequencer
//  rj_addr / rj_rd_l, rj_rd_r            shared rj read port, 1-cycle latency
//  coeff_addr_* / coeff_rd_*             per-lane coefficient read ports
//  data_addr_* / data_rd_*               per-lane data FIFO read ports
//  result_*, result_valid                frame results toward P2S
//  busy, ready, overrun, cfg_err         status
interface conv_sequencer_if;
  logic        cfg_done;
  logic        sample_valid;
  logic [7:0]  cur_addr;
  logic [3:0]  rj_addr;
  logic [15:0] rj_rd_l;
  logic [15:0] rj_rd_r;
  logic [8:0]  coeff_addr_l;
  logic [8:0]  coeff_addr_r;
  logic [15:0] coeff_rd_l;
  logic [15:0] coeff_rd_r;
  logic [7:0]  data_addr_l;
  logic [7:0]  data_addr_r;
  logic [15:0] data_rd_l;
  logic [15:0] data_rd_r;
  logic [39:0] result_l;
  logic [39:0] result_r;
  logic        result_valid;
  logic        busy;
  logic        ready;
  logic        overrun;
  logic        cfg_err;

  modport master (
    input  cfg_done, sample_valid, cur_addr,
    input  rj_rd_l, rj_rd_r, coeff_rd_l, coeff_rd_r, data_rd_l, data_rd_r,
    output rj_addr, coeff_addr_l, coeff_addr_r, data_addr_l, data_addr_r,
    output result_l, result_r, result_valid, busy, ready, overrun, cfg_err
  );

  modport slave (
    output cfg_done, sample_valid, cur_addr,
    output rj_rd_l, rj_rd_r, coeff_rd_l, coeff_rd_r, data_rd_l, data_rd_r,
    input  rj_addr, coeff_addr_l, coeff_addr_r, data_addr_l, data_addr_r,
    input  result_l, result_r, result_valid, busy, ready, overrun, cfg_err
  );
endinterface

// File: rtl/conv_sequencer.sv
// MSDAP convolution sequencer for the L and R channels.
// After cfg_done it scans the rj memory to build per-group coefficient counts and base
// addresses, then for every accepted sample runs two independent three-stage lanes
// (coeff fetch -> data fetch -> Horner accumulate) over groups 15..0.
// Ports:
//  SCLK   system clock
//  Reset  synchronous active-high reset
//  bus    conv_sequencer_if.master (handshake, memory read ports, results, status)
module conv_sequencer #(
  parameter int unsigned NGRP  = 16,
  parameter int unsigned NCOEF = 512,
  parameter int unsigned AW    = 40
) (
  input logic              SCLK,
  input logic              Reset,
  conv_sequencer_if.master bus
);

  typedef enum logic [1:0] {StUncfg, StPrescan, StReady, StRun} state_e;

  localparam logic [4:0]  ScanEnd = 5'(NGRP);
  localparam logic [13:0] CoefLim = 14'(NCOEF);

  state_e state_q, state_d;
  logic [4:0]            pc_q, pc_d;
  logic [7:0]            cur_q, cur_d;
  logic [1:0][15:0][8:0] cnt_q, cnt_d;
  logic [1:0][15:0][9:0] base_q, base_d;
  logic [1:0][13:0]      tot_q, tot_d;
  logic [1:0][3:0]       grp_q, grp_d;
  logic [1:0][8:0]       idx_q, idx_d;
  logic [1:0]            iss_q, iss_d;
  logic [1:0]            v1_q, v1_d, last1_q, last1_d, bub1_q, bub1_d, fin1_q, fin1_d;
  logic [1:0]            v2_q, v2_d, last2_q, last2_d, bub2_q, bub2_d, fin2_q, fin2_d;
  logic [1:0]            neg2_q, neg2_d;
  logic [1:0]            done_q, done_d;
  logic [1:0][AW-1:0]    acc_q, acc_d, res_q, res_d;
  logic                  rv_q, rv_d, ovr_q, ovr_d, err_q, err_d;

  logic [1:0][15:0] rj_rd, coeff_rd, data_rd;
  logic [1:0][8:0]  coeff_addr;
  logic [1:0][7:0]  data_addr;
  logic [3:0]       rj_addr;

  // Lane 0 is L, lane 1 is R.
  assign rj_rd    = {bus.rj_rd_r, bus.rj_rd_l};
  assign coeff_rd = {bus.coeff_rd_r, bus.coeff_rd_l};
  assign data_rd  = {bus.data_rd_r, bus.data_rd_l};

  logic unused_bits;
  assign unused_bits = ^{rj_rd[0][15:9], rj_rd[1][15:9], coeff_rd[0][15:9], coeff_rd[1][15:9]};

  always_comb begin
    logic [8:0]    c;
    logic          lastg;
    logic [9:0]    ca;
    logic [3:0]    slot;
    logic [AW-1:0] term, sum;
    c     = '0;
    lastg = 1'b0;
    ca    = '0;
    slot  = '0;
    term  = '0;
    sum   = '0;

    state_d = state_q;
    pc_d    = pc_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    tot_d   = tot_q;
    grp_d   = grp_q;
    idx_d   = idx_q;
    iss_d   = iss_q;
    v1_d    = '0;
    last1_d = '0;
    bub1_d  = '0;
    fin1_d  = '0;
    v2_d    = '0;
    last2_d = '0;
    bub2_d  = '0;
    fin2_d  = '0;
    neg2_d  = '0;
    done_d  = done_q;
    acc_d   = acc_q;
    res_d   = res_q;
    rv_d    = 1'b0;
    ovr_d   = ovr_q;
    err_d   = err_q;

    rj_addr    = '0;
    coeff_addr = '0;
    data_addr  = '0;

    unique case (state_q)
      StUncfg: begin
        if (bus.cfg_done) begin
          state_d = StPrescan;
          pc_d    = '0;
          tot_d   = '0;
        end
      end

      StPrescan: begin
        ovr_d = ovr_q | bus.sample_valid;
        if (pc_q < ScanEnd) rj_addr = pc_q[3:0];
        // rj data lags the address by one cycle, so slot pc-1 is captured now.
        if (pc_q != '0) begin
          slot = pc_q[3:0] - 4'd1;
          for (int unsigned l = 0; l < 2; l++) begin
            cnt_d[l][slot]  = rj_rd[l][8:0];
            base_d[l][slot] = tot_q[l][9:0];
            tot_d[l]        = tot_q[l] + {5'd0, rj_rd[l][8:0]};
          end
        end
        if (pc_q == ScanEnd) begin
          if (tot_d[0] > CoefLim || tot_d[1] > CoefLim) begin
            err_d   = 1'b1;
            state_d = StUncfg;
          end else begin
            state_d = StReady;
          end
        end else begin
          pc_d = pc_q + 5'd1;
        end
      end

      StReady: begin
        if (bus.cfg_done) begin
          state_d = StPrescan;
          pc_d    = '0;
          tot_d   = '0;
        end else if (bus.sample_valid) begin
          state_d = StRun;
          cur_d   = bus.cur_addr;
          acc_d   = '0;
          grp_d   = {4'hF, 4'hF};
          idx_d   = '0;
          iss_d   = 2'b11;
          done_d  = '0;
        end
      end

      StRun: begin
        ovr_d = ovr_q | bus.sample_valid;
        for (int unsigned l = 0; l < 2; l++) begin
          // Stage 0: walk groups 15..0; an empty group still takes one bubble slot.
          if (iss_q[l]) begin
            c          = cnt_q[l][grp_q[l]];
            lastg      = (c == 9'd0) || (idx_q[l] == c - 9'd1);
            v1_d[l]    = 1'b1;
            bub1_d[l]  = (c == 9'd0);
            last1_d[l] = lastg;
            fin1_d[l]  = lastg && (grp_q[l] == 4'd0);
            if (c != 9'd0) begin
              ca            = base_q[l][grp_q[l]] + {1'b0, idx_q[l]};
              coeff_addr[l] = ca[8:0];
            end
            if (lastg) begin
              idx_d[l] = '0;
              if (grp_q[l] == 4'd0) iss_d[l] = 1'b0;
              else                  grp_d[l] = grp_q[l] - 4'd1;
            end else begin
              idx_d[l] = idx_q[l] + 9'd1;
            end
          end
          // Stage 1: coefficient is back; fetch the delayed sample.
          v2_d[l]    = v1_q[l];
          last2_d[l] = last1_q[l];
          bub2_d[l]  = bub1_q[l];
          fin2_d[l]  = fin1_q[l];
          neg2_d[l]  = coeff_rd[l][8];
          if (v1_q[l] && !bub1_q[l]) data_addr[l] = cur_q - coeff_rd[l][7:0];
          // Stage 2: accumulate; the group's last slot (or bubble) halves the sum.
          if (v2_q[l]) begin
            term = {{(AW-16){data_rd[l][15]}}, data_rd[l]} << 16;
            if (neg2_q[l]) term = -term;
            sum      = bub2_q[l] ? acc_q[l] : acc_q[l] + term;
            acc_d[l] = last2_q[l] ? AW'($signed(sum) >>> 1) : sum;
            if (fin2_q[l]) done_d[l] = 1'b1;
          end
        end
        if (done_q == 2'b11) begin
          res_d   = acc_q;
          rv_d    = 1'b1;
          state_d = StReady;
        end
      end

      default: state_d = StUncfg;
    endcase
  end

  always_ff @(posedge SCLK) begin
    if (Reset) begin
      state_q <= StUncfg;
      pc_q    <= '0;
      cur_q   <= '0;
      cnt_q   <= '0;
      base_q  <= '0;
      tot_q   <= '0;
      grp_q   <= '0;
      idx_q   <= '0;
      iss_q   <= '0;
      v1_q    <= '0;
      last1_q <= '0;
      bub1_q  <= '0;
      fin1_q  <= '0;
      v2_q    <= '0;
      last2_q <= '0;
      bub2_q  <= '0;
      fin2_q  <= '0;
      neg2_q  <= '0;
      done_q  <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      rv_q    <= 1'b0;
      ovr_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      tot_q   <= tot_d;
      grp_q   <= grp_d;
      idx_q   <= idx_d;
      iss_q   <= iss_d;
      v1_q    <= v1_d;
      last1_q <= last1_d;
      bub1_q  <= bub1_d;
      fin1_q  <= fin1_d;
      v2_q    <= v2_d;
      last2_q <= last2_d;
      bub2_q  <= bub2_d;
      fin2_q  <= fin2_d;
      neg2_q  <= neg2_d;
      done_q  <= done_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      rv_q    <= rv_d;
      ovr_q   <= ovr_d;
      err_q   <= err_d;
    end
  end

  assign bus.rj_addr      = rj_addr;
  assign bus.coeff_addr_l = coeff_addr[0];
  assign bus.coeff_addr_r = coeff_addr[1];
  assign bus.data_addr_l  = data_addr[0];
  assign bus.data_addr_r  = data_addr[1];
  assign bus.result_l     = res_q[0];
  assign bus.result_r     = res_q[1];
  assign bus.result_valid = rv_q;
  assign bus.busy         = (state_q == StPrescan) || (state_q == StRun);
  assign bus.ready        = (state_q == StReady);
  assign bus.overrun      = ovr_q;
  assign bus.cfg_err      = err_q;

endmodule

// File: tb/tb_conv_sequencer.sv
// Self-checking bench for conv_sequencer: memory models, a frame-level reference model,
// a per-cycle compare process, and directed plus randomized stimulus.
module tb_conv_sequencer;
  logic SCLK = 1'b0;
  logic Reset;
  always #5 SCLK = ~SCLK;

  conv_sequencer_if bus ();
  conv_sequencer dut (.SCLK(SCLK), .Reset(Reset), .bus(bus));

  logic [15:0] rj_l [16];
  logic [15:0] rj_r [16];
  logic [15:0] coeff_l [512];
  logic [15:0] coeff_r [512];
  logic [15:0] data_l [256];
  logic [15:0] data_r [256];

  always @(posedge SCLK) begin
    bus.rj_rd_l    <= rj_l[bus.rj_addr];
    bus.rj_rd_r    <= rj_r[bus.rj_addr];
    bus.coeff_rd_l <= coeff_l[bus.coeff_addr_l];
    bus.coeff_rd_r <= coeff_r[bus.coeff_addr_r];
    bus.data_rd_l  <= data_l[bus.data_addr_l];
    bus.data_rd_r  <= data_r[bus.data_addr_r];
  end

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic int cnt_of(input int lane, input int j);
    logic [15:0] w;
    w = lane != 0 ? rj_r[j] : rj_l[j];
    return int'(w[8:0]);
  endfunction

  function automatic int total_of(input int lane);
    int n = 0;
    for (int j = 0; j < 16; j++) n += cnt_of(lane, j);
    return n;
  endfunction

  function automatic int ops_of(input int lane);
    int n = 0;
    for (int j = 0; j < 16; j++) n += (cnt_of(lane, j) == 0) ? 1 : cnt_of(lane, j);
    return n;
  endfunction

  function automatic int frame_len();
    int a, b;
    a = ops_of(0);
    b = ops_of(1);
    return (a > b ? a : b) + 3;
  endfunction

  // Each group: add every signed, scaled tap, then halve once.
  function automatic logic [39:0] lane_model(input int lane, input logic [7:0] cur);
    logic signed [39:0] acc, t;
    logic [15:0] cw, d;
    logic [7:0] da;
    int bases[16];
    int b;
    b = 0;
    for (int j = 0; j < 16; j++) begin
      bases[j] = b;
      b += cnt_of(lane, j);
    end
    acc = '0;
    for (int j = 15; j >= 0; j--) begin
      for (int i = 0; i < cnt_of(lane, j); i++) begin
        cw  = lane != 0 ? coeff_r[bases[j] + i] : coeff_l[bases[j] + i];
        da  = cur - cw[7:0];
        d   = lane != 0 ? data_r[da] : data_l[da];
        t   = $signed({{24{d[15]}}, d}) * 40'sd65536;
        acc = cw[8] ? acc - t : acc + t;
      end
      acc = acc >>> 1;
    end
    return acc;
  endfunction

  typedef enum {MUncfg, MScan, MReady, MRun} mstate_e;
  mstate_e     m_st;
  int          m_tmr, m_len;
  logic        e_ovr, e_err, e_rv;
  logic [39:0] e_res_l, e_res_r, p_l, p_r;

  always @(posedge SCLK) begin
    e_rv <= 1'b0;
    if (Reset) begin
      m_st <= MUncfg; m_tmr <= 0; e_ovr <= 1'b0; e_err <= 1'b0;
      e_res_l <= '0; e_res_r <= '0;
    end else begin
      case (m_st)
        MUncfg: if (bus.cfg_done) begin m_st <= MScan; m_tmr <= 0; end
        MScan: begin
          if (bus.sample_valid) e_ovr <= 1'b1;
          if (m_tmr == 16) begin
            if (total_of(0) > 512 || total_of(1) > 512) begin
              e_err <= 1'b1;
              m_st  <= MUncfg;
            end else begin
              m_st <= MReady;
            end
          end else begin
            m_tmr <= m_tmr + 1;
          end
        end
        MReady: begin
          if (bus.cfg_done) begin
            m_st <= MScan; m_tmr <= 0;
          end else if (bus.sample_valid) begin
            m_st  <= MRun;
            m_tmr <= 0;
            m_len <= frame_len();
            p_l   <= lane_model(0, bus.cur_addr);
            p_r   <= lane_model(1, bus.cur_addr);
          end
        end
        MRun: begin
          if (bus.sample_valid) e_ovr <= 1'b1;
          if (m_tmr == m_len - 1) begin
            m_st <= MReady; e_rv <= 1'b1; e_res_l <= p_l; e_res_r <= p_r;
          end else begin
            m_tmr <= m_tmr + 1;
          end
        end
        default: m_st <= MUncfg;
      endcase
    end
  end

  always @(negedge SCLK) begin
    if (chk_en) begin
      check("busy", 64'(bus.busy), 64'(m_st == MScan || m_st == MRun));
      check("ready", 64'(bus.ready), 64'(m_st == MReady));
      check("overrun", 64'(bus.overrun), 64'(e_ovr));
      check("cfg_err", 64'(bus.cfg_err), 64'(e_err));
      check("result_valid", 64'(bus.result_valid), 64'(e_rv));
      check("result_l", 64'(bus.result_l), 64'(e_res_l));
      check("result_r", 64'(bus.result_r), 64'(e_res_r));
      check("rj_addr", 64'(bus.rj_addr), 64'((m_st == MScan && m_tmr < 16) ? m_tmr : 0));
      if (m_st != MRun) begin
        check("coeff_addr_idle", 64'({bus.coeff_addr_l, bus.coeff_addr_r}), 64'd0);
        check("data_addr_idle", 64'({bus.data_addr_l, bus.data_addr_r}), 64'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] watch;
  bit         seen;

  task automatic tick();
    @(posedge SCLK);
    #1;
  endtask

  task automatic clear_mems();
    for (int i = 0; i < 16; i++) begin rj_l[i] = '0; rj_r[i] = '0; end
    for (int i = 0; i < 512; i++) begin coeff_l[i] = '0; coeff_r[i] = '0; end
    for (int i = 0; i < 256; i++) begin data_l[i] = '0; data_r[i] = '0; end
  endtask

  task automatic rand_data();
    for (int i = 0; i < 512; i++) begin
      coeff_l[i] = 16'($urandom);
      coeff_r[i] = 16'($urandom);
    end
    for (int i = 0; i < 256; i++) begin
      data_l[i] = 16'($urandom);
      data_r[i] = 16'($urandom);
    end
  endtask

  // Random counts capped so each lane total stays within 512; upper rj bits are noise.
  task automatic rand_rj(input int maxc);
    int tl, tr, c;
    tl = 0;
    tr = 0;
    for (int j = 0; j < 16; j++) begin
      c = $urandom_range(0, maxc);
      if (tl + c > 512) c = 0;
      tl += c;
      rj_l[j] = 16'($urandom & 32'hFE00) | 16'(c);
      c = $urandom_range(0, maxc);
      if (tr + c > 512) c = 0;
      tr += c;
      rj_r[j] = 16'($urandom & 32'hFE00) | 16'(c);
    end
  endtask

  task automatic do_cfg();
    bus.cfg_done = 1'b1;
    tick();
    bus.cfg_done = 1'b0;
    repeat (17) tick();
  endtask

  task automatic pulse_sample(input logic [7:0] cur);
    bus.cur_addr     = cur;
    bus.sample_valid = 1'b1;
    tick();
    bus.sample_valid = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] cur, input bit inject, output int cyc);
    pulse_sample(cur);
    cyc  = 0;
    seen = 1'b0;
    while (!bus.result_valid && cyc < 700) begin
      if (bus.data_addr_l == watch) seen = 1'b1;
      bus.sample_valid = inject && (cyc == 3);
      tick();
      cyc++;
    end
    bus.sample_valid = 1'b0;
    if (!bus.result_valid) check("frame_timeout", 64'(cyc), 64'(m_len));
    else check("frame_len", 64'(cyc), 64'(m_len));
  endtask

  initial begin
    int cyc;
    Reset = 1'b1;
    bus.cfg_done = 1'b0;
    bus.sample_valid = 1'b0;
    bus.cur_addr = '0;
    watch = 8'h00;
    clear_mems();
    tick();
    chk_en = 1'b1;
    check("rst_outputs", 64'({bus.busy, bus.ready, bus.result_valid, bus.result_l}), 64'd0);
    tick();
    Reset = 1'b0;

    // Sample while unconfigured is ignored without flags.
    pulse_sample(8'h10);
    repeat (3) tick();
    check("uncfg_busy", 64'(bus.busy), 64'd0);
    check("uncfg_overrun", 64'(bus.overrun), 64'd0);

    // One tap per group, zero delay: sum converges to 0x4000_0000 * (1 - 2^-16).
    for (int j = 0; j < 16; j++) begin rj_l[j] = 16'h0001; rj_r[j] = 16'hFE01; end
    data_l[8'h37] = 16'h4000;
    data_r[8'h37] = 16'h4000;
    check("model_t1", 64'(lane_model(0, 8'h37)), 64'h00_3FFF_C000);
    do_cfg();
    check("t1_ready", 64'(bus.ready), 64'd1);
    run_frame(8'h37, 1'b0, cyc);
    check("t1_res_l", 64'(bus.result_l), 64'h00_3FFF_C000);
    check("t1_res_r", 64'(bus.result_r), 64'h00_3FFF_C000);
    check("t1_within20", 64'(cyc <= 20), 64'd1);

    // Single negative tap in group 0, fifteen empty groups.
    clear_mems();
    rj_l[0] = 16'h0001; rj_r[0] = 16'h0001;
    coeff_l[0] = 16'h0100; coeff_r[0] = 16'h0100;
    data_l[8'h20] = 16'h0001; data_r[8'h20] = 16'h0001;
    check("model_t2", 64'(lane_model(1, 8'h20)), 64'h00FF_FFFF_8000);
    do_cfg();
    run_frame(8'h20, 1'b0, cyc);
    check("t2_res_l", 64'(bus.result_l), 64'h00FF_FFFF_8000);
    check("t2_res_r", 64'(bus.result_r), 64'h00FF_FFFF_8000);
    check("t2_bubble_len", 64'(cyc), 64'd19);

    // Delay 5 from address 2 wraps to 0xFD.
    coeff_l[0] = 16'h0005;
    data_l[8'hFD] = 16'h1234;
    watch = 8'hFD;
    run_frame(8'h02, 1'b0, cyc);
    check("wrap_seen", 64'(seen), 64'd1);
    check("wrap_res_l", 64'(bus.result_l), 64'h00_091A_0000);
    watch = 8'h00;

    // Overrun: extra sample mid-frame; this and the next frame still complete correctly.
    rand_rj(20);
    rand_data();
    do_cfg();
    run_frame(8'($urandom), 1'b1, cyc);
    check("overrun_set", 64'(bus.overrun), 64'd1);
    tick();
    run_frame(8'($urandom), 1'b0, cyc);

    // Randomized configurations and frames.
    for (int k = 0; k < 6; k++) begin
      rand_rj(k == 5 ? 200 : 8 * k);
      rand_data();
      do_cfg();
      for (int f = 0; f < 3; f++) begin
        run_frame(8'($urandom), 1'b0, cyc);
        tick();
        if (f == 1) rand_data();
      end
    end

    // Exactly 512 taps in one lane is legal.
    rand_rj(4);
    for (int j = 0; j < 16; j++) rj_l[j] = '0;
    rj_l[0] = 16'h01FF;
    rj_l[1] = 16'h0001;
    do_cfg();
    check("t512_ready", 64'(bus.ready), 64'd1);
    check("t512_no_err", 64'(bus.cfg_err), 64'd0);
    run_frame(8'($urandom), 1'b0, cyc);
    tick();

    // 513 taps: configuration error, back to unconfigured.
    rj_l[1] = 16'h0002;
    do_cfg();
    check("t513_err", 64'(bus.cfg_err), 64'd1);
    check("t513_not_ready", 64'(bus.ready), 64'd0);
    pulse_sample(8'h00);
    tick();
    check("t513_sample_ignored", 64'(bus.busy), 64'd0);

    // Reset in the middle of a frame.
    rj_l[1] = 16'h0001;
    do_cfg();
    pulse_sample(8'h44);
    repeat (5) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("rst_mid_busy", 64'(bus.busy), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.result_valid) seen = 1'b1;
    end
    check("rst_mid_no_rv", 64'(seen), 64'd0);
    pulse_sample(8'h44);
    tick();
    check("rst_needs_cfg", 64'(bus.busy), 64'd0);
    rand_rj(16);
    do_cfg();
    run_frame(8'($urandom), 1'b0, cyc);
    tick();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
